pipe_gen: RTL
=============

PIPE_GEN -- requirements
Module: pipe_gen

Interface
REQ-001 SHALL have parameter GS, default 8: grid size in rows; col_o width.
REQ-002 SHALL have parameter CR, default 14: prescaler width; scroll tick every 2^CR clocks.
REQ-003 SHALL have parameter GAP, default 3: pipe gap height in rows; legal range 1..GS/2.
REQ-004 SHALL have parameter SPACING, default 4: scroll ticks per pipe; legal range 2..15.
REQ-005 SHALL have port clk_i, input, 1: single clock; all state updates on rising edge.
REQ-006 SHALL have port reset_i, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port e_gen_i, input, 1: stage enable (request) from the game sequencer.
REQ-008 SHALL have port d_gen_o, output, 1: stage done, the acknowledge to e_gen_i.
REQ-009 SHALL have port shift_o, output, 1: matrix scrolls one column this frame; valid while d_gen_o=1.
REQ-010 SHALL have port col_o, output, GS: new rightmost column, 1 = wall; valid while d_gen_o=1.
REQ-011 SHALL have port new_pipe_o, output, 1: col_o holds a freshly emitted pipe; valid while d_gen_o=1.

Function
REQ-012 SHALL run a free-running CR-bit prescaler; on wrap (all ones to 0), tick_pending is set.
REQ-013 SHALL run a free-running 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, advancing every clock.
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; IDLE->CALC when e_gen_i=1; CALC->DONE always after one cycle; DONE->IDLE when e_gen_i=0.
REQ-015 SHALL, in CALC with tick_pending=0, latch shift_o=0, new_pipe_o=0, col_o=0.
REQ-016 SHALL, in CALC with tick_pending=1, clear tick_pending, set shift_o=1, and advance the spacing counter col_cnt.
REQ-017 SHALL, on a tick with col_cnt=SPACING-1, emit a pipe: col_cnt<=0, new_pipe_o=1, col_o all ones except rows gap_pos..gap_pos+GAP-1 zero.
REQ-018 SHALL, on a tick with col_cnt<SPACING-1, increment col_cnt and set col_o=0, new_pipe_o=0.
REQ-019 SHALL compute gap_pos = lfsr[log2(GS)-1:0]; if that exceeds GS-GAP, subtract GS-GAP+1.
REQ-020 SHALL assert d_gen_o in DONE only; latency from e_gen_i rise to d_gen_o=1 is exactly 2 clocks.
REQ-021 SHALL hold shift_o, col_o and new_pipe_o stable from CALC until the next CALC.
REQ-022 SHALL keep tick_pending set when a prescaler wrap coincides with a CALC consuming it; missed ticks are not queued beyond one.
REQ-023 SHALL let DONE last one cycle if e_gen_i already dropped before DONE.

Reset
REQ-024 SHALL, while reset_i=1, immediately force FSM=IDLE, d_gen_o=0, shift_o=0, new_pipe_o=0, col_o=0.
REQ-025 SHALL, on reset, set prescaler=0, tick_pending=0, col_cnt=0 and LFSR=8'hA5.
REQ-026 SHALL abort any handshake in progress on reset; the first request after release behaves as post-reset.

Configuration
REQ-027 SHALL, when PIPE_GEN_SCORE_EN is defined, add output score_o[7:0]: count of emitted pipes, reset 0, saturating at 255.
REQ-028 SHALL, when PIPE_GEN_SCORE_EN is undefined, omit score_o and its counter entirely; all other behaviour is identical.

Structure
REQ-029 SHALL take FSM state encodings, the LFSR seed 8'hA5, the tap mask and default GS from the shared flappy_pkg constants header.
REQ-030 SHALL instantiate the LFSR as sub-module flappy_lfsr (8-bit, seed input, enable tied high).

Verification
REQ-031 SHALL cover reset: assert reset_i mid-run -> col_o=0, d_gen_o=0, shift_o=0 and LFSR=8'hA5 without a clock edge.
REQ-032 SHALL cover request with no tick (CR=4, request 3 clocks after reset) -> d_gen_o=1 two clocks later, shift_o=0, col_o=0.
REQ-033 SHALL cover pipe cadence (CR=4, request once per 16-clock period) -> three frames with shift_o=1 and col_o=0, then on the 4th new_pipe_o=1 with exactly 3 consecutive zero rows.
REQ-034 SHALL cover gap mapping (GS=8, GAP=3): forced lfsr[2:0]=7 -> col_o=8'b11110001; lfsr[2:0]=3 -> col_o=8'b11000111.
REQ-035 SHALL cover handshake: e_gen_i held high -> d_gen_o stays 1 and no new CALC occurs; e_gen_i low -> IDLE next clock.
REQ-036 SHALL cover score (PIPE_GEN_SCORE_EN defined): 300 pipes emitted -> score_o=255; macro undefined -> the design elaborates without score_o.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared constants for the flappy game blocks: FSM encodings, LFSR seed/taps, grid default.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gen_state_t;

  localparam int         GS_DEFAULT = 8;
  localparam logic [7:0] LFSR_SEED  = 8'hA5;
  // x^8 + x^6 + x^5 + x^4 + 1, shift-left Fibonacci form: feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS  = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/flappy_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; advances on every enabled clock, one-cycle update.
// Asynchronous reset loads seed_i.
module flappy_lfsr
  import flappy_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       en_i,
  input  logic [7:0] seed_i,
  output logic [7:0] q_o
);

  logic [7:0] q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      q <= seed_i;
    end else if (en_i) begin
      q <= lfsr_step(q);
    end
  end

  assign q_o = q;

endmodule

// File: rtl/pipe_gen.sv
// Pipe column generator: request/ack stage producing the next scrolled column, 2-clock latency.
// Outputs hold until the next request; optional pipe score counter under PIPE_GEN_SCORE_EN.
module pipe_gen
  import flappy_pkg::*;
#(
  parameter int GS      = GS_DEFAULT,
  parameter int CR      = 14,
  parameter int GAP     = 3,
  parameter int SPACING = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          e_gen_i,
  output logic          d_gen_o,
  output logic          shift_o,
  output logic [GS-1:0] col_o,
`ifdef PIPE_GEN_SCORE_EN
  output logic          new_pipe_o,
  output logic [7:0]    score_o
`else
  output logic          new_pipe_o
`endif
);

  localparam int GW = (GS > 1) ? $clog2(GS) : 1;
  localparam int GAP_MAX = GS - GAP;
  localparam logic [3:0] CNT_LAST = 4'(SPACING - 1);

  gen_state_t state_q, state_d;

  logic [CR-1:0] presc_q;
  logic          presc_wrap;
  logic          tick_pending_q;
  logic          tick_take;
  logic [3:0]    col_cnt_q;
  logic [7:0]    lfsr_q;
  logic [GW-1:0] gap_raw;
  int            gap_pos;
  logic [GS-1:0] pipe_col;
  logic          emit_pipe;

  flappy_lfsr u_lfsr (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (1'b1),
    .seed_i (LFSR_SEED),
    .q_o    (lfsr_q)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    d_gen_o = 1'b0;
    case (state_q)
      IDLE: if (e_gen_i) state_d = CALC;
      CALC: state_d = DONE;
      DONE: begin
        d_gen_o = 1'b1;
        if (!e_gen_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign presc_wrap = &presc_q;
  assign tick_take  = (state_q == CALC) && tick_pending_q;
  assign emit_pipe  = tick_take && (col_cnt_q == CNT_LAST);

  // Gap start folds out-of-range random values back into 0..GS-GAP.
  always_comb begin
    gap_raw = lfsr_q[GW-1:0];
    gap_pos = int'(gap_raw);
    if (gap_pos > GAP_MAX) gap_pos = gap_pos - (GAP_MAX + 1);
    pipe_col = '1;
    for (int r = 0; r < GS; r++) begin
      if ((r >= gap_pos) && (r < gap_pos + GAP)) pipe_col[r] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      presc_q        <= '0;
      tick_pending_q <= 1'b0;
    end else begin
      presc_q <= presc_q + 1'b1;
      // A wrap landing on the consuming CALC wins, so that tick is not lost.
      if (presc_wrap) begin
        tick_pending_q <= 1'b1;
      end else if (tick_take) begin
        tick_pending_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      col_cnt_q  <= '0;
      shift_o    <= 1'b0;
      new_pipe_o <= 1'b0;
      col_o      <= '0;
    end else if (state_q == CALC) begin
      if (!tick_pending_q) begin
        shift_o    <= 1'b0;
        new_pipe_o <= 1'b0;
        col_o      <= '0;
      end else if (emit_pipe) begin
        shift_o    <= 1'b1;
        new_pipe_o <= 1'b1;
        col_o      <= pipe_col;
        col_cnt_q  <= '0;
      end else begin
        shift_o    <= 1'b1;
        new_pipe_o <= 1'b0;
        col_o      <= '0;
        col_cnt_q  <= col_cnt_q + 1'b1;
      end
    end
  end

`ifdef PIPE_GEN_SCORE_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      score_o <= '0;
    end else if (emit_pipe && (score_o != 8'hFF)) begin
      score_o <= score_o + 1'b1;
    end
  end
`endif

endmodule
